// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the audio DAC feeder.
//   state_t     - feeder FSM state encoding
//   SAMPLE_MAX  - largest signed sample for the default sample width
//   SAMPLE_MIN  - smallest signed sample for the default sample width
//   UNITY_GAIN  - volume code that passes samples through unchanged
package audio_pkg;

  localparam int AUDIO_DATA_WIDTH = 16;
  localparam int AUDIO_VOL_WIDTH  = 8;
  localparam int AUDIO_VOL_SHIFT  = 7;

  localparam logic [AUDIO_DATA_WIDTH-1:0] SAMPLE_MAX = {1'b0, {(AUDIO_DATA_WIDTH-1){1'b1}}};
  localparam logic [AUDIO_DATA_WIDTH-1:0] SAMPLE_MIN = {1'b1, {(AUDIO_DATA_WIDTH-1){1'b0}}};
  localparam int                          UNITY_GAIN = 1 << AUDIO_VOL_SHIFT;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCALE = 3'd1,
    ST_WR_L  = 3'd2,
    ST_GAP_L = 3'd3,
    ST_WR_R  = 3'd4,
    ST_GAP_R = 3'd5
  } state_t;

endpackage

// File: rtl/audio_gain_sat.sv
// audio_gain_sat: combinational gain for one channel.
//   sample - signed input sample
//   vol    - unsigned volume code
//   result - (sample * vol) >>> VOL_SHIFT, clamped to the signed sample range
//   sat    - high when clamping occurred
module audio_gain_sat #(
  parameter int DATA_WIDTH = 16,
  parameter int VOL_WIDTH  = 8,
  parameter int VOL_SHIFT  = 7
) (
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [VOL_WIDTH-1:0]  vol,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  sat
);

  localparam int PW = DATA_WIDTH + VOL_WIDTH + 1;

  // Bounds sign-extended to product width so comparisons stay signed.
  localparam logic signed [PW-1:0] MAXV = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [PW-1:0] product;
  logic signed [PW-1:0] shifted;

  // Volume is zero-extended by one bit so the multiply treats it as unsigned.
  assign product = PW'($signed(sample)) * PW'($signed({1'b0, vol}));
  assign shifted = product >>> VOL_SHIFT;

  always_comb begin
    sat    = 1'b0;
    result = shifted[DATA_WIDTH-1:0];
    if (shifted > MAXV) begin
      sat    = 1'b1;
      result = MAXV[DATA_WIDTH-1:0];
    end else if (shifted < MINV) begin
      sat    = 1'b1;
      result = MINV[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/audio_dac_feeder.sv
// audio_dac_feeder: accepts stereo pairs, applies master volume with
// saturation, and writes left then right into the DAC FIFO.
//   clk, reset        - system clock, synchronous active-high reset
//   enable            - permits acceptance of new pairs
//   vol               - unsigned volume, captured with the pair
//   s_valid/s_ready   - upstream pair handshake; s_left/s_right samples
//   fifo_writedata    - word to DAC FIFO; fifo_write strobe; fifo_full flag
//   busy              - a pair is in flight
//   sat_count         - saturated-channel counter (only with
//                       AUDIO_DAC_FEEDER_SAT_COUNT_EN defined)
module audio_dac_feeder
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter int VOL_WIDTH  = AUDIO_VOL_WIDTH,
  parameter int VOL_SHIFT  = AUDIO_VOL_SHIFT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [VOL_WIDTH-1:0]  vol,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_left,
  input  logic [DATA_WIDTH-1:0] s_right,
  output logic [DATA_WIDTH-1:0] fifo_writedata,
  output logic                  fifo_write,
  input  logic                  fifo_full,
`ifdef AUDIO_DAC_FEEDER_SAT_COUNT_EN
  output logic [15:0]           sat_count,
`endif
  output logic                  busy
);

  state_t                state;
  logic [DATA_WIDTH-1:0] samp_l, samp_r, res_l, res_r, gain_l, gain_r;
  logic [VOL_WIDTH-1:0]  vol_q;
  logic                  sat_l, sat_r;

  audio_gain_sat #(.DATA_WIDTH(DATA_WIDTH), .VOL_WIDTH(VOL_WIDTH), .VOL_SHIFT(VOL_SHIFT))
    u_gain_l (.sample(samp_l), .vol(vol_q), .result(gain_l), .sat(sat_l));
  audio_gain_sat #(.DATA_WIDTH(DATA_WIDTH), .VOL_WIDTH(VOL_WIDTH), .VOL_SHIFT(VOL_SHIFT))
    u_gain_r (.sample(samp_r), .vol(vol_q), .result(gain_r), .sat(sat_r));

  assign s_ready = (state == ST_IDLE) && enable && !reset;
  assign busy    = (state != ST_IDLE);

  always_comb begin
    fifo_write     = 1'b0;
    fifo_writedata = '0;
    if (state == ST_WR_L) begin
      fifo_write     = !fifo_full;
      fifo_writedata = res_l;
    end else if (state == ST_WR_R) begin
      fifo_write     = !fifo_full;
      fifo_writedata = res_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      samp_l <= '0;
      samp_r <= '0;
      vol_q  <= '0;
      res_l  <= '0;
      res_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (s_valid && s_ready) begin
          samp_l <= s_left;
          samp_r <= s_right;
          vol_q  <= vol;
          state  <= ST_SCALE;
        end
        ST_SCALE: begin
          res_l <= gain_l;
          res_r <= gain_r;
          state <= ST_WR_L;
        end
        // Gap cycles let the FIFO's registered full flag catch up.
        ST_WR_L:  if (fifo_write) state <= ST_GAP_L;
        ST_GAP_L: state <= ST_WR_R;
        ST_WR_R:  if (fifo_write) state <= ST_GAP_R;
        ST_GAP_R: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef AUDIO_DAC_FEEDER_SAT_COUNT_EN
  logic [16:0] sat_sum;
  assign sat_sum = {1'b0, sat_count} + 17'({1'b0, sat_l} + {1'b0, sat_r});

  always_ff @(posedge clk) begin
    if (reset)
      sat_count <= '0;
    else if (state == ST_SCALE)
      sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end
`else
  logic sat_unused;
  assign sat_unused = sat_l | sat_r;
`endif

endmodule

// File: tb/tb_audio_dac_feeder.sv
// tb_audio_dac_feeder: directed bench for audio_dac_feeder.
module tb_audio_dac_feeder;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  vol = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_left = '0, s_right = '0;
  logic [15:0] fifo_writedata;
  logic        fifo_write;
  logic        fifo_full = 1'b0;
  logic        busy;
`ifdef AUDIO_DAC_FEEDER_SAT_COUNT_EN
  logic [15:0] sat_count;
`endif

  audio_dac_feeder dut (
    .clk(clk), .reset(reset), .enable(enable), .vol(vol),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .fifo_writedata(fifo_writedata), .fifo_write(fifo_write), .fifo_full(fifo_full),
`ifdef AUDIO_DAC_FEEDER_SAT_COUNT_EN
    .sat_count(sat_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] wd[$];
  int          wc[$];
  int          hs[$];

  // Log every FIFO write and every accepted handshake by edge index.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_write) begin
      wd.push_back(fifo_writedata);
      wc.push_back(cyc);
    end
    if (s_valid && s_ready) hs.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wd.delete(); wc.delete(); hs.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_timeout"}, 32'(n >= 100), 32'd0);
  endtask

  // Offer one pair, drop s_valid after it is accepted; optionally wait out the pair.
  task automatic offer_pair(input string tag, input logic [15:0] l, input logic [15:0] r,
                            input logic [7:0] v);
    int n = 0;
    int h0 = hs.size();
    s_left = l; s_right = r; vol = v; s_valid = 1'b1;
    while (hs.size() == h0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept_timeout"}, 32'(n >= 50), 32'd0);
    s_valid = 1'b0;
  endtask

  logic [15:0] bl[4] = '{16'h0011, 16'h0033, 16'h0055, 16'h0077};
  logic [15:0] br[4] = '{16'h0022, 16'h0044, 16'h0066, 16'h0088};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fifo_write", 32'(fifo_write), 32'd0);
    chk("rst_writedata", 32'(fifo_writedata), 32'd0);
`ifdef AUDIO_DAC_FEEDER_SAT_COUNT_EN
    chk("rst_sat_count", 32'(sat_count), 32'd0);
`endif
    reset = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", 32'(s_ready), 32'd1);

    // Unity gain, latency
    clear_logs();
    offer_pair("unity", 16'h1234, 16'hEDCC, 8'(UNITY_GAIN));
    wait_idle("unity");
    chk("unity_nwr", 32'(wd.size()), 32'd2);
    if (wd.size() == 2) begin
      chk("unity_l", 32'(wd[0]), 32'h1234);
      chk("unity_r", 32'(wd[1]), 32'hEDCC);
      chk("unity_lat_l", 32'(wc[0] - hs[0]), 32'd2);
      chk("unity_lat_r", 32'(wc[1] - hs[0]), 32'd4);
    end

    // Both channels saturate
    clear_logs();
    offer_pair("sat", 16'h7000, 16'h9000, 8'd255);
    wait_idle("sat");
    chk("sat_nwr", 32'(wd.size()), 32'd2);
    if (wd.size() == 2) begin
      chk("sat_l", 32'(wd[0]), 32'(SAMPLE_MAX));
      chk("sat_r", 32'(wd[1]), 32'(SAMPLE_MIN));
    end
`ifdef AUDIO_DAC_FEEDER_SAT_COUNT_EN
    chk("sat_count", 32'(sat_count), 32'd2);
`endif

    // Half gain, arithmetic shift floors -1
    clear_logs();
    offer_pair("half", 16'hFFFF, 16'h0003, 8'd64);
    wait_idle("half");
    chk("half_nwr", 32'(wd.size()), 32'd2);
    if (wd.size() == 2) begin
      chk("half_l", 32'(wd[0]), 32'hFFFF);
      chk("half_r", 32'(wd[1]), 32'h0001);
    end

    // Zero volume
    clear_logs();
    offer_pair("mute", 16'h4000, 16'h8000, 8'd0);
    wait_idle("mute");
    chk("mute_nwr", 32'(wd.size()), 32'd2);
    if (wd.size() == 2) begin
      chk("mute_l", 32'(wd[0]), 32'h0000);
      chk("mute_r", 32'(wd[1]), 32'h0000);
    end

    // FIFO full for 10 cycles while the right word waits
    clear_logs();
    begin
      int n = 0;
      int bad = 0;
      offer_pair("full", 16'h0100, 16'h0200, 8'd128);
      while (wc.size() == 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("full_left_timeout", 32'(n >= 20), 32'd0);
      fifo_full = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (fifo_write !== 1'b0 || fifo_writedata !== 16'h0200 || busy !== 1'b1) bad++;
      end
      chk("full_stall_bad_cycles", 32'(bad), 32'd0);
      @(negedge clk);
      fifo_full = 1'b0;
      #1;
      chk("full_release_write", 32'(fifo_write), 32'd1);
      wait_idle("full");
      chk("full_nwr", 32'(wd.size()), 32'd2);
      if (wd.size() == 2) begin
        chk("full_r", 32'(wd[1]), 32'h0200);
        chk("full_gap", 32'(wc[1] - wc[0]), 32'd12);
      end
    end

    // Four back-to-back pairs, s_valid held high
    clear_logs();
    begin
      int n = 0;
      int bad = 0;
      s_valid = 1'b1; vol = 8'd128;
      while (hs.size() < 4 && n < 60) begin
        s_left = bl[hs.size()];
        s_right = br[hs.size()];
        @(negedge clk);
        n++;
      end
      s_valid = 1'b0;
      chk("b2b_accept_timeout", 32'(n >= 60), 32'd0);
      wait_idle("b2b");
      chk("b2b_nwr", 32'(wd.size()), 32'd8);
      if (wd.size() == 8 && hs.size() == 4) begin
        for (int i = 0; i < 4; i++) begin
          if (wd[2*i] !== bl[i] || wd[2*i+1] !== br[i]) bad++;
          if (i > 0 && hs[i] - hs[i-1] != 6) bad++;
        end
        for (int i = 1; i < 8; i++)
          if (wc[i] - wc[i-1] < 2) bad++;
        chk("b2b_order_spacing", 32'(bad), 32'd0);
      end
    end

    // enable dropped mid-pair: pair completes, nothing new accepted
    clear_logs();
    begin
      offer_pair("en", 16'h0ABC, 16'h0DEF, 8'd128);
      enable = 1'b0;
      s_valid = 1'b1;
      repeat (10) @(negedge clk);
      chk("en_s_ready", 32'(s_ready), 32'd0);
      chk("en_nhs", 32'(hs.size()), 32'd1);
      chk("en_nwr", 32'(wd.size()), 32'd2);
      if (wd.size() == 2) chk("en_r", 32'(wd[1]), 32'h0DEF);
      s_valid = 1'b0;
      enable = 1'b1;
    end

    // Reset in GAP_L abandons the pair
    clear_logs();
    begin
      int n = 0;
      offer_pair("rstmid", 16'h0F0F, 16'h0E0E, 8'd128);
      while (wc.size() == 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("rstmid_left_timeout", 32'(n >= 20), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_fifo_write", 32'(fifo_write), 32'd0);
      chk("rstmid_s_ready", 32'(s_ready), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      clear_logs();
      offer_pair("after", 16'h0AAA, 16'h0BBB, 8'd128);
      wait_idle("after");
      chk("after_nwr", 32'(wd.size()), 32'd2);
      if (wd.size() == 2) begin
        chk("after_l", 32'(wd[0]), 32'h0AAA);
        chk("after_r", 32'(wd[1]), 32'h0BBB);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
